// File: rtl/vga_grid_renderer_if.sv
// Map-load, cursor and video-output bundle between the game-of-life core, the
// grid renderer and the VGA/HDMI transmitter.
interface vga_grid_renderer_if #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8
);
    localparam int CUR_XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int CUR_YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

    logic [GRID_W*GRID_H-1:0] map_in;
    logic                     map_load;
    logic                     map_pending;
    logic [CUR_XW-1:0]        cursor_x;
    logic [CUR_YW-1:0]        cursor_y;
    logic                     cursor_en;
    logic                     frame_start;
    logic                     vga_hs;
    logic                     vga_vs;
    logic                     vga_de;
    logic [7:0]               vga_r;
    logic [7:0]               vga_g;
    logic [7:0]               vga_b;

    modport master (
        output map_in, map_load, cursor_x, cursor_y, cursor_en,
        input  map_pending, frame_start, vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b
    );

    modport slave (
        input  map_in, map_load, cursor_x, cursor_y, cursor_en,
        output map_pending, frame_start, vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_grid_renderer.sv
// Double-buffered cell-grid VGA renderer with outlines and cursor highlight.
// Optional CURSOR_BLINK_EN macro adds a frame-counted cursor blink.
module vga_grid_renderer #(
    parameter int GRID_W       = 8,
    parameter int GRID_H       = 8,
    parameter int CELL_W       = 16,
    parameter int CELL_H       = 16,
    parameter int BORDER       = 1,
    parameter int BLINK_FRAMES = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [11:0]       h_total,
    input  logic [11:0]       h_sync,
    input  logic [11:0]       h_start,
    input  logic [11:0]       h_end,
    input  logic [11:0]       v_total,
    input  logic [11:0]       v_sync,
    input  logic [11:0]       v_start,
    input  logic [11:0]       v_end,
    vga_grid_renderer_if.slave bus
);
    localparam int NCELL = GRID_W * GRID_H;
    localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int PXW   = $clog2(CELL_W);
    localparam int PYW   = $clog2(CELL_H);
    localparam int CXW   = $clog2(GRID_W + 1);
    localparam int CYW   = $clog2(GRID_H + 1);

    if (CELL_W < 2*BORDER + 1 || CELL_H < 2*BORDER + 1 || BLINK_FRAMES < 1) begin : g_param_check
        $error("vga_grid_renderer: illegal cell/border/blink parameters");
    end

    logic [11:0]      h_count_q, v_count_q, v_next;
    logic             line_end, frame_end;
    logic [NCELL-1:0] disp_q, pend_q;
    logic             pending_q, frame_start_q;
    logic             active1_q, hs1_q, vs1_q;
    logic [PXW-1:0]   px_q;
    logic [PYW-1:0]   py_q;
    logic [CXW-1:0]   cx_q;
    logic [CYW-1:0]   cy_q;
    logic             in_grid, border, on_cursor, blink_on;
    logic [IW-1:0]    cell_idx;
    logic [23:0]      rgb_d, rgb_q;
    logic             hs_q, vs_q, de_q;

    always_comb begin
        line_end  = (h_count_q == h_total);
        frame_end = line_end && (v_count_q == v_total);
        v_next    = (v_count_q == v_total) ? '0 : v_count_q + 12'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_count_q <= '0;
            v_count_q <= '0;
        end else begin
            h_count_q <= line_end ? '0 : h_count_q + 12'd1;
            if (line_end) v_count_q <= v_next;
        end
    end

    // A load landing on the boundary cycle bypasses the pending buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_q        <= '0;
            pend_q        <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_end;
            if (frame_end) begin
                pending_q <= 1'b0;
                if (bus.map_load)   disp_q <= bus.map_in;
                else if (pending_q) disp_q <= pend_q;
            end else if (bus.map_load) begin
                pend_q    <= bus.map_in;
                pending_q <= 1'b1;
            end
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else if (frame_start_q) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
        end
    end
    assign blink_on = blink_q;
`else
    assign blink_on = 1'b1;
`endif

    // Stage 1: cell sub-counters saturate at the grid size so pixels past
    // the grid never alias back onto a real cell.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active1_q <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            px_q      <= '0;
            cx_q      <= '0;
            py_q      <= '0;
            cy_q      <= '0;
        end else begin
            active1_q <= (h_count_q >= h_start) && (h_count_q < h_end) &&
                         (v_count_q >= v_start) && (v_count_q < v_end);
            hs1_q     <= (h_count_q >= h_sync);
            vs1_q     <= (v_count_q >= v_sync);
            if (h_count_q == h_start) begin
                px_q <= '0;
                cx_q <= '0;
            end else if (px_q == PXW'(CELL_W - 1)) begin
                px_q <= '0;
                if (cx_q != CXW'(GRID_W)) cx_q <= cx_q + CXW'(1);
            end else begin
                px_q <= px_q + PXW'(1);
            end
            if (line_end) begin
                if (v_next == v_start) begin
                    py_q <= '0;
                    cy_q <= '0;
                end else if (py_q == PYW'(CELL_H - 1)) begin
                    py_q <= '0;
                    if (cy_q != CYW'(GRID_H)) cy_q <= cy_q + CYW'(1);
                end else begin
                    py_q <= py_q + PYW'(1);
                end
            end
        end
    end

    always_comb begin
        in_grid   = (cx_q < CXW'(GRID_W)) && (cy_q < CYW'(GRID_H));
        border    = (px_q < PXW'(BORDER)) || (px_q >= PXW'(CELL_W - BORDER)) ||
                    (py_q < PYW'(BORDER)) || (py_q >= PYW'(CELL_H - BORDER));
        on_cursor = bus.cursor_en && blink_on &&
                    (cx_q == CXW'(bus.cursor_x)) && (cy_q == CYW'(bus.cursor_y));
        cell_idx  = IW'(cy_q) * IW'(GRID_W) + IW'(cx_q);
        rgb_d     = 24'h000000;
        if (active1_q) begin
            if (!in_grid)              rgb_d = 24'hFFFFFF;
            else if (border)           rgb_d = on_cursor ? 24'hFF5C39 : 24'h32D8E0;
            else if (disp_q[cell_idx]) rgb_d = 24'h12AFAF;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            de_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs_q  <= hs1_q;
            vs_q  <= vs1_q;
            de_q  <= active1_q;
            rgb_q <= rgb_d;
        end
    end

    assign bus.map_pending = pending_q;
    assign bus.frame_start = frame_start_q;
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.vga_de      = de_q;
    assign bus.vga_r       = rgb_q[23:16];
    assign bus.vga_g       = rgb_q[15:8];
    assign bus.vga_b       = rgb_q[7:0];
endmodule
